// File: rtl/dff_bist.sv
// Self-test engine for one D flip-flop: LFSR stimulus on dut_d, delayed-compare checker on dut_q.
// Optional response MISR on the signature output is built when DFF_BIST_MISR_EN is defined.
module dff_bist #(
    parameter int         NUM_VECTORS = 32,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        dut_d,
    input  logic        dut_q,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // An all-zero seed would lock the LFSR up.
    localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;
    logic        drain_cnt_q, drain_cnt_d;
    logic        dut_d_q, dut_d_d;
    logic        drv_q, drv_d;
    logic        vld_q, vld_d;
    logic        exp_q, exp_d;
    logic [7:0]  err_q, err_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;

    logic        clear_run;
    logic        drive;
    logic        finish;
    logic        busy_o;
    logic        lfsr_fb;
    logic        mismatch;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (vec_cnt_q == LAST_VEC) state_d = DRAIN;
            DRAIN:   if (drain_cnt_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / controls ----------------
    always_comb begin
        clear_run = 1'b0;
        drive     = 1'b0;
        finish    = 1'b0;
        busy_o    = 1'b0;
        case (state_q)
            IDLE:    clear_run = start;
            RUN: begin
                drive  = 1'b1;
                busy_o = 1'b1;
            end
            DRAIN:   busy_o = 1'b1;
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

    // ---------------- stimulus generator ----------------
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4];

    always_comb begin
        lfsr_d      = lfsr_q;
        vec_cnt_d   = vec_cnt_q;
        dut_d_d     = dut_d_q;
        drain_cnt_d = 1'b0;
        if (clear_run) begin
            lfsr_d    = SEED_EFF;
            vec_cnt_d = '0;
        end else if (drive) begin
            lfsr_d    = {lfsr_fb, lfsr_q[7:1]};
            vec_cnt_d = vec_cnt_q + 16'd1;
            dut_d_d   = lfsr_q[0];
        end
        if (state_q == DRAIN) begin
            drain_cnt_d = ~drain_cnt_q;
        end
    end

    // ---------------- checker pipeline ----------------
    // drv marks a fresh vector on dut_d; vld follows one edge later when the flop has captured it.
    assign mismatch = vld_q && (dut_q != exp_q);

    always_comb begin
        drv_d  = drive;
        vld_d  = drv_q;
        exp_d  = dut_d_q;
        err_d  = err_q;
        pass_d = pass_q;
        done_d = finish;
        if (clear_run) begin
            err_d  = '0;
            pass_d = 1'b0;
        end else begin
            if (mismatch && (err_q != 8'hFF)) begin
                err_d = err_q + 8'd1;
            end
            if (finish) begin
                pass_d = (err_q == 8'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q      <= SEED_EFF;
            vec_cnt_q   <= '0;
            drain_cnt_q <= 1'b0;
            dut_d_q     <= 1'b0;
            drv_q       <= 1'b0;
            vld_q       <= 1'b0;
            exp_q       <= 1'b0;
            err_q       <= '0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            vec_cnt_q   <= vec_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            dut_d_q     <= dut_d_d;
            drv_q       <= drv_d;
            vld_q       <= vld_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
        end
    end

    // ---------------- response signature ----------------
`ifdef DFF_BIST_MISR_EN
    logic [15:0] misr_q, misr_d;

    always_comb begin
        misr_d = misr_q;
        if (clear_run) begin
            misr_d = '0;
        end else if (vld_q) begin
            misr_d = {misr_q[14:0], 1'b0} ^ ((misr_q[15] ^ dut_q) ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misr_q <= '0;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign signature = misr_q;
`else
    assign signature = 16'h0000;
`endif

    assign dut_d     = dut_d_q;
    assign busy      = busy_o;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_dff_bist.sv
// Scoreboard bench for dff_bist: stimulus pushes expected run results, a negedge monitor
// pops one entry per done pulse. A second instance with 300 vectors covers error saturation.
module tb_dff_bist;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic        dut_d, dut_q, busy, done, pass;
    logic [7:0]  err_count;
    logic [15:0] signature;
    logic        dut_d_s, dut_q_s, busy_s, done_s, pass_s;
    logic [7:0]  err_count_s;
    logic [15:0] signature_s;
    logic        ff, ff_s;
    int          mode = 0;

    typedef struct {
        int          stc;
        int          n;
        logic [7:0]  err;
        logic        pass;
        logic [15:0] sig;
    } exp_t;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t em, es;
    int   total = 0, bad = 0, cyc = 0, ndone = 0, nacc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // flops under test: one ideal, one feeding the saturation instance
    always @(posedge clk or negedge rstn) begin
        if (!rstn) ff <= 1'b0;
        else       ff <= dut_d;
    end
    always @(posedge clk or negedge rstn) begin
        if (!rstn) ff_s <= 1'b0;
        else       ff_s <= dut_d_s;
    end

    assign dut_q   = (mode == 1) ? ~ff : (mode == 2) ? 1'b0 : ff;
    assign dut_q_s = ~ff_s;

    dff_bist u_dut (
        .clk(clk), .rstn(rstn), .start(start), .dut_d(dut_d), .dut_q(dut_q),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .signature(signature)
    );

    dff_bist #(.NUM_VECTORS(300), .SEED(8'hA5)) u_sat (
        .clk(clk), .rstn(rstn), .start(start_s), .dut_d(dut_d_s), .dut_q(dut_q_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s), .signature(signature_s)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[4], l[7:1]};
    endfunction

    function automatic logic vec_bit(input int k);
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 1; i < k; i++) l = lfsr_step(l);
        return l[0];
    endfunction

    function automatic exp_t model(input int md, input int n, input int stc);
        exp_t        e;
        logic [7:0]  l;
        logic        b, q;
        logic [15:0] m;
        int          err;
        l = 8'hA5; m = 16'h0; err = 0;
        for (int i = 0; i < n; i++) begin
            b = l[0];
            l = lfsr_step(l);
            q = (md == 1) ? ~b : (md == 2) ? 1'b0 : b;
            if (q != b && err < 255) err++;
            m = {m[14:0], 1'b0} ^ ((m[15] ^ q) ? 16'h1021 : 16'h0000);
        end
        e.stc  = stc;
        e.n    = n;
        e.err  = 8'(err);
        e.pass = (err == 0);
`ifdef DFF_BIST_MISR_EN
        e.sig  = m;
`else
        e.sig  = 16'h0000;
`endif
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // monitor: one scoreboard entry per done pulse
    always @(negedge clk) begin
        if (done === 1'b1) begin
            ndone++;
            if (q_m.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                em = q_m.pop_front();
                chk("latency", cyc - em.stc, em.n + 3);
                chk("err_count", {24'h0, err_count}, {24'h0, em.err});
                chk("pass", {31'h0, pass}, {31'h0, em.pass});
                chk("signature", {16'h0, signature}, {16'h0, em.sig});
            end
        end
        if (done_s === 1'b1) begin
            ndone++;
            if (q_s.size() == 0) chk("unexpected_done_sat", 32'd1, 32'd0);
            else begin
                es = q_s.pop_front();
                chk("sat_latency", cyc - es.stc, es.n + 3);
                chk("sat_err_count", {24'h0, err_count_s}, {24'h0, es.err});
                chk("sat_pass", {31'h0, pass_s}, {31'h0, es.pass});
                chk("sat_signature", {16'h0, signature_s}, {16'h0, es.sig});
            end
        end
    end

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_dut_d"}, {31'h0, dut_d}, 32'd0);
        chk({nm, "_busy"}, {31'h0, busy}, 32'd0);
        chk({nm, "_done"}, {31'h0, done}, 32'd0);
        chk({nm, "_pass"}, {31'h0, pass}, 32'd0);
        chk({nm, "_err"}, {24'h0, err_count}, 32'd0);
        chk({nm, "_sig"}, {16'h0, signature}, 32'd0);
    endtask

    // leaves the caller at the negedge after the start-sampling edge
    task automatic pulse_start(input bit expect_done);
        @(negedge clk);
        start = 1'b1;
        if (expect_done) begin
            q_m.push_back(model(mode, 32, cyc + 1));
            nacc++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        int n;
        n = 0;
        while ((q_m.size() != 0 || q_s.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q_m.size() + q_s.size(), 32'd0);
    endtask

    task automatic run_seq(input int md);
        mode = md;
        pulse_start(1'b1);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            chk($sformatf("dut_d_%0d", k), {31'h0, dut_d}, {31'h0, vec_bit(k)});
        end
        @(negedge clk);
        chk("busy_drain", {31'h0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_done_state", {31'h0, busy}, 32'd0);
        wait_drain(20);
    endtask

    initial begin
        #1;
        check_idle_outputs("reset");
        #20;
        @(negedge clk);
        rstn = 1'b1;

        run_seq(0);
        repeat (3) @(negedge clk);
        chk("pass_hold", {31'h0, pass}, 32'd1);
        run_seq(1);
        run_seq(2);

        // reset in the middle of a failing run
        mode = 1;
        pulse_start(1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("rst_run_dut_d_%0d", k), {31'h0, dut_d}, {31'h0, vec_bit(k)});
            if (k == 2) chk("err_before_first_check", {24'h0, err_count}, 32'd0);
            if (k == 3) chk("err_first_check", {24'h0, err_count}, 32'd1);
        end
        chk("err_at_cycle10", {24'h0, err_count}, 32'd8);
        rstn = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        run_seq(0);

        // start during RUN and during DONE is ignored; held into IDLE it starts one more run
        mode = 0;
        pulse_start(1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        chk("in_done_busy", {31'h0, busy}, 32'd0);
        start = 1'b1;
        q_m.push_back(model(0, 32, cyc + 2));
        nacc++;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_drain(60);
        repeat (5) @(negedge clk);
        chk("no_extra_run", {31'h0, busy}, 32'd0);

        // 300 vectors of inverted q saturate the error counter
        @(negedge clk);
        start_s = 1'b1;
        q_s.push_back(model(1, 300, cyc + 1));
        nacc++;
        @(negedge clk);
        start_s = 1'b0;
        wait_drain(600);

        repeat (5) @(negedge clk);
        chk("done_count", ndone, nacc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
